fetch_unit: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline. It owns the PC register, drives the instruction-memory request port, and loads the IF/ID pipeline register (InstrD, PCPlus4D, ValidD). It consumes the redirect targets produced in decode: the branch target PCBranchD with PCSrcD, and the jump target PCJumpD with JumpD. It absorbs variable instruction-memory latency, decode stalls, and redirects that arrive while a request is outstanding.

---
 rtl/fetch_unit.sv | 220 ++++++++++++++++++++++
 tb/tb_fetch_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the PC register,
// issues instruction-memory requests, and loads the IF/ID pipeline register.
// It tolerates variable memory latency and decode stalls. It also handles
// redirects (branch or jump) that arrive while a request is still outstanding.
//
// Optional feature macro: FETCH_PERF_CNT_EN
//   When defined, two performance counters are added as output ports:
//   FetchCntF counts instructions delivered into IF/ID.
//   DropCntF counts discarded (wrong-path) responses.
// -----------------------------------------------------------------------------
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   // decode-stage control
   input  logic        StallD,
   input  logic        FlushD,
   input  logic        PCSrcD,
   input  logic [31:0] PCBranchD,
   input  logic        JumpD,
   input  logic [31:0] PCJumpD,
   // instruction-memory port
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_valid,
   input  logic [31:0] imem_rdata,
   // fetch PC and IF/ID register
   output logic [31:0] PCF,
   output logic [31:0] InstrD,
   output logic [31:0] PCPlus4D,
`ifdef FETCH_PERF_CNT_EN
   output logic        ValidD,
   output logic [31:0] FetchCntF,
   output logic [31:0] DropCntF
`else
   output logic        ValidD
`endif
);

   // FETCH: the request for PCF is outstanding.
   // DROP : the outstanding request is wrong-path, so its response is discarded.
   // HOLD : a response is parked in the hold buffer until decode stops stalling.
   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_DROP  = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   state_t      state_reg, state_next;
   logic [31:0] pc_reg, pc_next;
   logic [31:0] redirect_pc_reg, redirect_pc_next;
   logic [31:0] hold_instr_reg, hold_instr_next;
   logic [31:0] hold_pc4_reg, hold_pc4_next;

   logic [31:0] instr_d_reg;
   logic [31:0] pc_plus4_d_reg;
   logic        valid_d_reg;

   // Decode-side redirect. A jump wins over a taken branch.
   logic        redirect;
   logic [31:0] target;
   logic [31:0] pc_plus4;

   // Request to load IF/ID this cycle, and the data to load.
   logic        load_ifid;
   logic [31:0] load_instr;
   logic [31:0] load_pc4;

   // Set when a memory response is thrown away as wrong-path.
   logic        drop_resp;

   assign redirect = JumpD | PCSrcD;
   assign target   = JumpD ? PCJumpD : PCBranchD;
   // Modulo-2^32 increment. The low two bits pass through untouched.
   assign pc_plus4 = pc_reg + 32'd4;

   // Hold off requests while reset is asserted and while a response waits in HOLD.
   assign imem_req  = !reset && (state_reg != S_HOLD);
   assign imem_addr = pc_reg;
   assign PCF       = pc_reg;

   assign InstrD   = instr_d_reg;
   assign PCPlus4D = pc_plus4_d_reg;
   assign ValidD   = valid_d_reg;

   // Next-state logic, plus the PC, redirect and hold-buffer updates.
   always_comb begin
      state_next       = state_reg;
      pc_next          = pc_reg;
      redirect_pc_next = redirect_pc_reg;
      hold_instr_next  = hold_instr_reg;
      hold_pc4_next    = hold_pc4_reg;
      load_ifid        = 1'b0;
      load_instr       = imem_rdata;
      load_pc4         = pc_plus4;
      drop_resp        = 1'b0;

      case (state_reg)
         S_FETCH: begin
            if (imem_valid) begin
               if (redirect) begin
                  // The response arrived together with a redirect, so it is wrong-path.
                  drop_resp = 1'b1;
                  pc_next   = target;
               end else if (StallD) begin
                  // Decode cannot accept the word yet, so park it and stop requesting.
                  hold_instr_next = imem_rdata;
                  hold_pc4_next   = pc_plus4;
                  pc_next         = pc_plus4;
                  state_next      = S_HOLD;
               end else begin
                  load_ifid = 1'b1;
                  pc_next   = pc_plus4;
               end
            end else if (redirect) begin
               // PCF must stay stable until the pending response returns,
               // so remember where to go afterwards.
               redirect_pc_next = target;
               state_next       = S_DROP;
            end
         end

         S_DROP: begin
            if (imem_valid) begin
               drop_resp  = 1'b1;
               pc_next    = redirect ? target : redirect_pc_reg;
               state_next = S_FETCH;
            end else if (redirect) begin
               // A later redirect replaces the earlier one.
               redirect_pc_next = target;
            end
         end

         S_HOLD: begin
            if (redirect) begin
               // The parked word is wrong-path. The redirect wins over delivery.
               hold_instr_next = 32'd0;
               hold_pc4_next   = 32'd0;
               pc_next         = target;
               state_next      = S_FETCH;
            end else if (!StallD) begin
               load_ifid  = 1'b1;
               load_instr = hold_instr_reg;
               load_pc4   = hold_pc4_reg;
               state_next = S_FETCH;
            end
         end

         default: begin
            state_next = S_FETCH;
         end
      endcase
   end

   // State register, PC, redirect target and hold buffer.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= S_FETCH;
         pc_reg          <= RESET_PC;
         redirect_pc_reg <= 32'd0;
         hold_instr_reg  <= 32'd0;
         hold_pc4_reg    <= 32'd0;
      end else begin
         state_reg       <= state_next;
         pc_reg          <= pc_next;
         redirect_pc_reg <= redirect_pc_next;
         hold_instr_reg  <= hold_instr_next;
         hold_pc4_reg    <= hold_pc4_next;
      end
   end

   // IF/ID register. Priority is flush, then stall, then load, then bubble.
   always_ff @(posedge clk) begin
      if (reset) begin
         instr_d_reg    <= 32'd0;
         pc_plus4_d_reg <= 32'd0;
         valid_d_reg    <= 1'b0;
      end else if (FlushD) begin
         instr_d_reg    <= 32'd0;
         pc_plus4_d_reg <= 32'd0;
         valid_d_reg    <= 1'b0;
      end else if (StallD) begin
         valid_d_reg    <= valid_d_reg;
      end else if (load_ifid) begin
         instr_d_reg    <= load_instr;
         pc_plus4_d_reg <= load_pc4;
         valid_d_reg    <= 1'b1;
      end else begin
         valid_d_reg    <= 1'b0;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt_reg;
   logic [31:0] drop_cnt_reg;

   assign FetchCntF = fetch_cnt_reg;
   assign DropCntF  = drop_cnt_reg;

   // Performance counters. A load that FlushD overrides is not counted,
   // because it never reaches IF/ID.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_cnt_reg <= 32'd0;
         drop_cnt_reg  <= 32'd0;
      end else begin
         if (load_ifid && !FlushD && !StallD) begin
            fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
         end
         if (drop_resp) begin
            drop_cnt_reg <= drop_cnt_reg + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit. The bench acts as the instruction memory and
// drives hand-picked response words. Every step applies inputs 1 ns after a
// rising edge, then waits for the next edge plus 1 ns before checking outputs.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

   logic        clk;
   logic        reset;
   logic        StallD;
   logic        FlushD;
   logic        PCSrcD;
   logic [31:0] PCBranchD;
   logic        JumpD;
   logic [31:0] PCJumpD;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_valid;
   logic [31:0] imem_rdata;
   logic [31:0] PCF;
   logic [31:0] InstrD;
   logic [31:0] PCPlus4D;
   logic        ValidD;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] FetchCntF;
   logic [31:0] DropCntF;
`endif

   int n_cmp;
   int n_err;

   fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk        (clk),
      .reset      (reset),
      .StallD     (StallD),
      .FlushD     (FlushD),
      .PCSrcD     (PCSrcD),
      .PCBranchD  (PCBranchD),
      .JumpD      (JumpD),
      .PCJumpD    (PCJumpD),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_valid (imem_valid),
      .imem_rdata (imem_rdata),
      .PCF        (PCF),
      .InstrD     (InstrD),
      .PCPlus4D   (PCPlus4D),
`ifdef FETCH_PERF_CNT_EN
      .ValidD     (ValidD),
      .FetchCntF  (FetchCntF),
      .DropCntF   (DropCntF)
`else
      .ValidD     (ValidD)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its expected value.
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Apply the inputs for one cycle, then move to 1 ns after the next rising edge.
   task automatic step(input logic v, input logic [31:0] rd, input logic st, input logic fl,
                       input logic br, input logic [31:0] bt, input logic jp, input logic [31:0] jt);
      imem_valid = v;
      imem_rdata = rd;
      StallD     = st;
      FlushD     = fl;
      PCSrcD     = br;
      PCBranchD  = bt;
      JumpD      = jp;
      PCJumpD    = jt;
      @(posedge clk);
      #1;
   endtask

   // Check the fetch PC and the whole IF/ID register.
   task automatic chk_ifid(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                           input logic [31:0] p4, input logic vd);
      chk({tag, ".PCF"}, PCF, pc);
      chk({tag, ".InstrD"}, InstrD, ins);
      chk({tag, ".PCPlus4D"}, PCPlus4D, p4);
      chk({tag, ".ValidD"}, {31'd0, ValidD}, {31'd0, vd});
      $display("step %-10s PCF=%h InstrD=%h PCPlus4D=%h ValidD=%0b req=%0b",
               tag, PCF, InstrD, PCPlus4D, ValidD, imem_req);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b1;
      step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      // Assert imem_valid during reset. The DUT must ignore it.
      step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      chk("rst.req", {31'd0, imem_req}, 32'd0);
      chk_ifid("rst", 32'h0, 32'h0, 32'h0, 1'b0);

      reset = 1'b0;
      imem_valid = 1'b0;
      #1;
      chk("post_rst.req", {31'd0, imem_req}, 32'd1);
      chk("post_rst.addr", imem_addr, 32'h0);

      // Sequential fetch with a zero-wait memory.
      step(1'b1, 32'hA000_0000, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      chk_ifid("seq0", 32'h4, 32'hA000_0000, 32'h4, 1'b1);
      step(1'b1, 32'hA000_0004, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      chk_ifid("seq1", 32'h8, 32'hA000_0004, 32'h8, 1'b1);

      // Response for PC=8 arrives while decode is stalled, which parks it in HOLD.
      step(1'b1, 32'hA000_0008, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      chk_ifid("hold0", 32'hC, 32'hA000_0004, 32'h8, 1'b1);
      chk("hold0.req", {31'd0, imem_req}, 32'd0);
      step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      chk_ifid("hold1", 32'hC, 32'hA000_0004, 32'h8, 1'b1);
      step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      chk_ifid("hold2", 32'hC, 32'hA000_0004, 32'h8, 1'b1);
      chk("hold2.req", {31'd0, imem_req}, 32'd0);
      step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      chk_ifid("release", 32'hC, 32'hA000_0008, 32'hC, 1'b1);
      chk("release.req", {31'd0, imem_req}, 32'd1);
      chk("release.addr", imem_addr, 32'hC);
      step(1'b1, 32'hA000_000C, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      chk_ifid("seq3", 32'h10, 32'hA000_000C, 32'h10, 1'b1);

      // A branch arrives while the request for 16 is still pending.
      step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'd0);
      chk_ifid("drop0", 32'h10, 32'hA000_000C, 32'h10, 1'b0);
      chk("drop0.addr", imem_addr, 32'h10);
      step(1'b1, 32'hA000_0010, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      chk_ifid("drop1", 32'h40, 32'hA000_000C, 32'h10, 1'b0);
      chk("drop1.addr", imem_addr, 32'h40);
`ifdef FETCH_PERF_CNT_EN
      chk("drop1.DropCntF", DropCntF, 32'd1);
`endif
      step(1'b1, 32'hA000_0040, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      chk_ifid("tgt", 32'h44, 32'hA000_0040, 32'h44, 1'b1);

      // Branch and jump in the same cycle as the response: the jump must win.
      step(1'b1, 32'hA000_0044, 1'b0, 1'b0, 1'b1, 32'h80, 1'b1, 32'h100);
      chk_ifid("jmp", 32'h100, 32'hA000_0040, 32'h44, 1'b0);
      step(1'b1, 32'hA000_0100, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      chk_ifid("jmp_tgt", 32'h104, 32'hA000_0100, 32'h104, 1'b1);

      // FlushD overrides StallD.
      step(1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
      chk_ifid("flush", 32'h104, 32'h0, 32'h0, 1'b0);

      // Jump to the top of the address space, then wrap around.
      step(1'b1, 32'hA000_0104, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFC);
      chk_ifid("to_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
      step(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      chk_ifid("wrap", 32'h0, 32'h1234_5678, 32'h0, 1'b1);
`ifdef FETCH_PERF_CNT_EN
      chk("wrap.FetchCntF", FetchCntF, 32'd7);
      chk("wrap.DropCntF", DropCntF, 32'd3);
`endif

      // A redirect in HOLD wins over delivering the parked word.
      step(1'b1, 32'hBBBB_0000, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      chk_ifid("hold_r0", 32'h4, 32'h1234_5678, 32'h0, 1'b1);
      step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h200);
      chk_ifid("hold_r1", 32'h200, 32'h1234_5678, 32'h0, 1'b0);
      chk("hold_r1.req", {31'd0, imem_req}, 32'd1);

      // Reset in DROP: the pending redirect is abandoned, and a late response
      // is taken as the word for RESET_PC.
      step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h300, 1'b0, 32'd0);
      chk_ifid("pre_rst", 32'h200, 32'h1234_5678, 32'h0, 1'b0);
      reset = 1'b1;
      step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      chk_ifid("rst2", 32'h0, 32'h0, 32'h0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
      chk("rst2.FetchCntF", FetchCntF, 32'd0);
`endif
      reset = 1'b0;
      step(1'b1, 32'hA000_0000, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      chk_ifid("late", 32'h4, 32'hA000_0000, 32'h4, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
